// File: rtl/iso14443a_defs.sv
// Shared definitions for the ISO14443-A tag-side datapath: FSM states,
// Manchester sequence codes, timing defaults and HF mode constants.
package iso14443a_defs;

  // Default timing: fc/128 bit period (106 kbit/s) and fc/16 subcarrier
  localparam int BIT_CYCLES_DEF  = 128;
  localparam int SUBC_CYCLES_DEF = 16;

  // HF mode selector values shared with the top-level mode mux
  localparam logic [2:0] FPGA_HF_ISO14443A_SNIFFER      = 3'd0;
  localparam logic [2:0] FPGA_HF_ISO14443A_TAGSIM_LISTEN = 3'd1;
  localparam logic [2:0] FPGA_HF_ISO14443A_TAGSIM_MOD    = 3'd2;
  localparam logic [2:0] FPGA_HF_ISO14443A_READER_LISTEN = 3'd3;
  localparam logic [2:0] FPGA_HF_ISO14443A_READER_MOD    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SOF    = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_EOF    = 3'd4
  } tx_state_e;

  // D: modulate first half, E: modulate second half, F: no modulation
  typedef enum logic [1:0] {
    SEQ_D = 2'd0,
    SEQ_E = 2'd1,
    SEQ_F = 2'd2
  } seq_e;

  // Load modulation level for a sequence at the current position in the bit
  function automatic logic seq_mod(seq_e seq, logic first_half, logic subc_phase);
    case (seq)
      SEQ_D:   return first_half & subc_phase;
      SEQ_E:   return ~first_half & subc_phase;
      default: return 1'b0;
    endcase
  endfunction

  // Odd parity: total count of ones including the parity bit is odd
  function automatic logic odd_parity(logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/iso14443a_bit_timer.sv
// Free-running carrier-cycle counter that frames bit periods and derives the
// half-bit and subcarrier phase used by the Manchester coder.
module iso14443a_bit_timer
  import iso14443a_defs::*;
#(
  parameter int BIT_CYCLES  = BIT_CYCLES_DEF,
  parameter int SUBC_CYCLES = SUBC_CYCLES_DEF
) (
  input  logic ck_1356meg,
  input  logic reset,
  output logic bit_end,
  output logic first_half,
  output logic subc_phase
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam int SW = $clog2(SUBC_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = 1;

  logic [CW-1:0] cnt_reg;

  // Counter wraps naturally because BIT_CYCLES is a power of two
  always_ff @(negedge ck_1356meg or posedge reset) begin
    if (reset) cnt_reg <= '0;
    else       cnt_reg <= cnt_reg + CNT_ONE;
  end

  assign bit_end    = &cnt_reg;
  assign first_half = ~cnt_reg[CW-1];
  assign subc_phase = ~cnt_reg[SW-1];

endmodule

// File: rtl/iso14443a_tag_tx.sv
// Tag-side ISO14443-A transmitter: takes bytes over valid/ready, adds odd
// parity, frames with SOF/EOF and emits Manchester load modulation on fc/16.
module iso14443a_tag_tx
  import iso14443a_defs::*;
#(
  parameter int BIT_CYCLES  = BIT_CYCLES_DEF,
  parameter int SUBC_CYCLES = SUBC_CYCLES_DEF
) (
  input  logic       ck_1356meg,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       tx_last,
  input  logic [2:0] tx_last_bits,
  input  logic       tx_parity_en,
  output logic       mod_sig,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_underrun
);

  tx_state_e  state_reg, state_next;
  seq_e       seq;
  logic       bit_end, first_half, subc_phase;

  logic       hold_full_reg, hold_last_reg;
  logic [7:0] hold_data_reg;
  logic [2:0] hold_last_bits_reg;

  logic [7:0] shift_reg;
  logic [3:0] bits_left_reg;
  logic       byte_last_reg, byte_partial_reg, parity_reg, parity_en_reg;
  logic       mod_reg, mod_next;

  logic       accept, load, shift, byte_end, underrun, latch_par;

  iso14443a_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES),
    .SUBC_CYCLES(SUBC_CYCLES)
  ) u_bit_timer (
    .ck_1356meg(ck_1356meg),
    .reset     (reset),
    .bit_end   (bit_end),
    .first_half(first_half),
    .subc_phase(subc_phase)
  );

  assign accept  = tx_valid & ~hold_full_reg;
  assign mod_sig = mod_reg;

  // State register
  always_ff @(negedge ck_1356meg or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and datapath control; everything moves only at bit boundaries
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    shift      = 1'b0;
    byte_end   = 1'b0;
    underrun   = 1'b0;
    latch_par  = 1'b0;
    if (bit_end) begin
      case (state_reg)
        ST_IDLE: begin
          if (hold_full_reg) begin
            state_next = ST_SOF;
            latch_par  = 1'b1;
          end
        end
        ST_SOF: begin
          state_next = ST_DATA;
          load       = 1'b1;
        end
        ST_DATA: begin
          if (bits_left_reg > 4'd1)                      shift      = 1'b1;
          else if (parity_en_reg && !byte_partial_reg)   state_next = ST_PARITY;
          else                                           byte_end   = 1'b1;
        end
        ST_PARITY: byte_end = 1'b1;
        default:   state_next = ST_IDLE;
      endcase
      // Shared end-of-byte decision: finish, chain the next byte, or abort
      if (byte_end) begin
        if (byte_last_reg) begin
          state_next = ST_EOF;
        end else if (hold_full_reg) begin
          state_next = ST_DATA;
          load       = 1'b1;
        end else begin
          state_next = ST_EOF;
          underrun   = 1'b1;
        end
      end
    end
  end

  // Output decode: sequence selection, modulation level and status flags
  always_comb begin
    case (state_reg)
      ST_SOF:    seq = SEQ_D;
      ST_DATA:   seq = shift_reg[0] ? SEQ_D : SEQ_E;
      ST_PARITY: seq = parity_reg ? SEQ_D : SEQ_E;
      default:   seq = SEQ_F;
    endcase
    mod_next    = seq_mod(seq, first_half, subc_phase);
    busy        = (state_reg != ST_IDLE);
    tx_done     = (state_reg == ST_EOF) && bit_end;
    tx_underrun = underrun;
    tx_ready    = ~hold_full_reg;
  end

  // Single-entry holding register between the ARM side and the shifter
  always_ff @(negedge ck_1356meg or posedge reset) begin
    if (reset) begin
      hold_full_reg      <= 1'b0;
      hold_data_reg      <= '0;
      hold_last_reg      <= 1'b0;
      hold_last_bits_reg <= '0;
    end else begin
      if (accept) begin
        hold_data_reg      <= tx_data;
        hold_last_reg      <= tx_last;
        hold_last_bits_reg <= tx_last_bits;
      end
      if (accept)    hold_full_reg <= 1'b1;
      else if (load) hold_full_reg <= 1'b0;
    end
  end

  // Shifter with per-byte bit count, parity and frame-end attributes
  always_ff @(negedge ck_1356meg or posedge reset) begin
    if (reset) begin
      shift_reg        <= '0;
      bits_left_reg    <= '0;
      byte_last_reg    <= 1'b0;
      byte_partial_reg <= 1'b0;
      parity_reg       <= 1'b0;
      parity_en_reg    <= 1'b0;
    end else begin
      if (load) begin
        shift_reg        <= hold_data_reg;
        bits_left_reg    <= (hold_last_reg && hold_last_bits_reg != 3'd0)
                            ? {1'b0, hold_last_bits_reg} : 4'd8;
        byte_last_reg    <= hold_last_reg;
        byte_partial_reg <= hold_last_reg && (hold_last_bits_reg != 3'd0);
        parity_reg       <= odd_parity(hold_data_reg);
      end else if (shift) begin
        shift_reg     <= {1'b0, shift_reg[7:1]};
        bits_left_reg <= bits_left_reg - 4'd1;
      end
      if (latch_par) parity_en_reg <= tx_parity_en;
    end
  end

  // Registered modulation output, one cycle behind the coder
  always_ff @(negedge ck_1356meg or posedge reset) begin
    if (reset) mod_reg <= 1'b0;
    else       mod_reg <= mod_next;
  end

endmodule
